// File: rtl/countdown_core.sv
// countdown_core: loadable seconds countdown timer with start/pause control,
// expiry flagging and a sequential subtract-based conversion of the remaining
// count into four display digits (tens-minutes, minutes, tens-seconds, seconds).
module countdown_core #(
  parameter int MAX_SECONDS = 3600,
  parameter int SEC_W       = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [SEC_W-1:0] seconds_in,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             tick,
  output logic [SEC_W-1:0] remaining,
  output logic [3:0]       tens_minutes,
  output logic [3:0]       minutes,
  output logic [3:0]       tens_seconds,
  output logic [3:0]       seconds,
  output logic             digits_valid,
  output logic             running,
  output logic             expired,
  output logic             alarm_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAUSED,
    ST_RUNNING,
    ST_EXPIRED
  } state_t;

  // Converter phases; seconds digit is taken straight from the residue when
  // no further subtraction applies, so it needs no phase of its own.
  typedef enum logic [1:0] {
    CV_IDLE,
    CV_TENS_MIN,
    CV_MIN,
    CV_TENS_SEC
  } cv_t;

  localparam logic [SEC_W-1:0] MAX_V  = SEC_W'(MAX_SECONDS);
  localparam logic [SEC_W-1:0] K_600  = SEC_W'(600);
  localparam logic [SEC_W-1:0] K_60   = SEC_W'(60);
  localparam logic [SEC_W-1:0] K_10   = SEC_W'(10);
  localparam logic [SEC_W-1:0] K_ONE  = SEC_W'(1);

  // Clamp happens before storage so the datapath never holds more than MAX_V.
  function automatic logic [SEC_W-1:0] clamp_seconds(input logic [SEC_W-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Control state
  state_t           state_q,     state_d;
  logic [SEC_W-1:0] remaining_q, remaining_d;
  logic             expired_q,   expired_d;
  logic             alarm_q,     alarm_d;
  logic             running_q,   running_d;
  logic [SEC_W-1:0] load_val;

  // Converter state
  cv_t              cv_q,        cv_d;
  logic [SEC_W-1:0] w_q,         w_d;
  logic [3:0]       tm_cnt_q,    tm_cnt_d;
  logic [3:0]       m_cnt_q,     m_cnt_d;
  logic [3:0]       ts_cnt_q,    ts_cnt_d;
  logic [3:0]       tens_min_q,  tens_min_d;
  logic [3:0]       min_q,       min_d;
  logic [3:0]       tens_sec_q,  tens_sec_d;
  logic [3:0]       sec_q,       sec_d;
  logic             dv_q,        dv_d;
  logic             rem_change;
  logic             in_phase_a;
  logic             in_phase_ab;
  logic             cv_busy;

  // Control next-state: clear > load > start_stop > tick, one strobe per cycle.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    expired_d   = expired_q;
    alarm_d     = 1'b0;
    load_val    = clamp_seconds(seconds_in);

    if (clear) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      expired_d   = 1'b0;
    end else if (load) begin
      // A load while running is swallowed: the timer has to be paused first.
      if (state_q != ST_RUNNING) begin
        remaining_d = load_val;
        state_d     = (load_val != '0) ? ST_PAUSED : ST_IDLE;
        expired_d   = 1'b0;
      end
    end else if (start_stop) begin
      case (state_q)
        ST_PAUSED:  state_d = ST_RUNNING;
        ST_RUNNING: state_d = ST_PAUSED;
        default:    state_d = state_q;
      endcase
    end else if (tick) begin
      if (state_q == ST_RUNNING) begin
        if (remaining_q == K_ONE) begin
          remaining_d = '0;
          state_d     = ST_EXPIRED;
          expired_d   = 1'b1;
          alarm_d     = 1'b1;
        end else if (remaining_q != '0) begin
          remaining_d = remaining_q - K_ONE;
        end
      end
    end

    running_d = (state_d == ST_RUNNING);
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      expired_q   <= 1'b0;
      alarm_q     <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      expired_q   <= expired_d;
      alarm_q     <= alarm_d;
      running_q   <= running_d;
    end
  end

  // Converter next-state: restart on any change of remaining, otherwise do one
  // subtraction per cycle, dropping to the next smaller weight without a
  // wasted cycle, and publish all four digits together when none applies.
  always_comb begin
    cv_d       = cv_q;
    w_d        = w_q;
    tm_cnt_d   = tm_cnt_q;
    m_cnt_d    = m_cnt_q;
    ts_cnt_d   = ts_cnt_q;
    tens_min_d = tens_min_q;
    min_d      = min_q;
    tens_sec_d = tens_sec_q;
    sec_d      = sec_q;
    dv_d       = dv_q;

    rem_change  = (remaining_d != remaining_q);
    in_phase_a  = (cv_q == CV_TENS_MIN);
    in_phase_ab = (cv_q == CV_TENS_MIN) || (cv_q == CV_MIN);
    cv_busy     = (cv_q != CV_IDLE);

    if (rem_change) begin
      // Starting from the value being stored this edge means any conversion
      // in flight is abandoned and its stale result can never be published.
      cv_d     = CV_TENS_MIN;
      w_d      = remaining_d;
      tm_cnt_d = '0;
      m_cnt_d  = '0;
      ts_cnt_d = '0;
      dv_d     = 1'b0;
    end else if (in_phase_a && (w_q >= K_600)) begin
      w_d      = w_q - K_600;
      tm_cnt_d = tm_cnt_q + 4'd1;
    end else if (in_phase_ab && (w_q >= K_60)) begin
      cv_d     = CV_MIN;
      w_d      = w_q - K_60;
      m_cnt_d  = m_cnt_q + 4'd1;
    end else if (cv_busy && (w_q >= K_10)) begin
      cv_d     = CV_TENS_SEC;
      w_d      = w_q - K_10;
      ts_cnt_d = ts_cnt_q + 4'd1;
    end else if (cv_busy) begin
      cv_d       = CV_IDLE;
      tens_min_d = tm_cnt_q;
      min_d      = m_cnt_q;
      tens_sec_d = ts_cnt_q;
      sec_d      = w_q[3:0];
      dv_d       = 1'b1;
    end
  end

  // Converter registers; reset shows 0:00 as a valid display of remaining=0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cv_q       <= CV_IDLE;
      w_q        <= '0;
      tm_cnt_q   <= '0;
      m_cnt_q    <= '0;
      ts_cnt_q   <= '0;
      tens_min_q <= '0;
      min_q      <= '0;
      tens_sec_q <= '0;
      sec_q      <= '0;
      dv_q       <= 1'b1;
    end else begin
      cv_q       <= cv_d;
      w_q        <= w_d;
      tm_cnt_q   <= tm_cnt_d;
      m_cnt_q    <= m_cnt_d;
      ts_cnt_q   <= ts_cnt_d;
      tens_min_q <= tens_min_d;
      min_q      <= min_d;
      tens_sec_q <= tens_sec_d;
      sec_q      <= sec_d;
      dv_q       <= dv_d;
    end
  end

  assign remaining    = remaining_q;
  assign tens_minutes = tens_min_q;
  assign minutes      = min_q;
  assign tens_seconds = tens_sec_q;
  assign seconds      = sec_q;
  assign digits_valid = dv_q;
  assign running      = running_q;
  assign expired      = expired_q;
  assign alarm_pulse  = alarm_q;

endmodule

// File: tb/tb_countdown_core.sv
// Directed testbench for countdown_core.
module tb_countdown_core;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [11:0] seconds_in;
  logic        start_stop;
  logic        clear;
  logic        tick;
  logic [11:0] remaining;
  logic [3:0]  tens_minutes;
  logic [3:0]  minutes;
  logic [3:0]  tens_seconds;
  logic [3:0]  seconds;
  logic        digits_valid;
  logic        running;
  logic        expired;
  logic        alarm_pulse;

  int errors = 0;
  int checks = 0;

  countdown_core #(.MAX_SECONDS(3600), .SEC_W(12)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .seconds_in   (seconds_in),
    .start_stop   (start_stop),
    .clear        (clear),
    .tick         (tick),
    .remaining    (remaining),
    .tens_minutes (tens_minutes),
    .minutes      (minutes),
    .tens_seconds (tens_seconds),
    .seconds      (seconds),
    .digits_valid (digits_valid),
    .running      (running),
    .expired      (expired),
    .alarm_pulse  (alarm_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] digs();
    return {tens_minutes, minutes, tens_seconds, seconds};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Apply strobes for exactly one active edge; outputs are then sampled 1ns after it.
  task automatic strobe(input logic l, input logic [11:0] v, input logic s,
                        input logic c, input logic t);
    load = l; seconds_in = v; start_stop = s; clear = c; tick = t;
    cyc();
    load = 1'b0; start_stop = 1'b0; clear = 1'b0; tick = 1'b0;
  endtask

  task automatic wait_valid(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 30; i++) begin
      if (digits_valid) begin
        ok = 1'b1;
        break;
      end
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load = 1'b0; seconds_in = '0; start_stop = 1'b0; clear = 1'b0; tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (remaining !== 12'd0) begin errors++; $display("FAIL por_remaining: got %0d want 0", remaining); end
    checks++; if (digs() !== 16'h0000) begin errors++; $display("FAIL por_digits: got %h want 0000", digs()); end
    checks++; if (digits_valid !== 1'b1) begin errors++; $display("FAIL por_dv: got %b want 1", digits_valid); end
    checks++; if ({running, expired, alarm_pulse} !== 3'b000) begin errors++; $display("FAIL por_flags: got %b want 000", {running, expired, alarm_pulse}); end
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_load_convert();
    bit ok; int n;
    strobe(1'b1, 12'd754, 1'b0, 1'b0, 1'b0);
    checks++; if (remaining !== 12'd754) begin errors++; $display("FAIL load754_remaining: got %0d want 754", remaining); end
    checks++; if (digits_valid !== 1'b0) begin errors++; $display("FAIL load754_dv_low: got %b want 0", digits_valid); end
    wait_valid(ok, n);
    checks++; if (!ok || n > 22) begin errors++; $display("FAIL load754_latency: got ok=%0d cycles=%0d want <=22", ok, n); end
    checks++; if (digs() !== 16'h1234) begin errors++; $display("FAIL load754_digits: got %h want 1234", digs()); end
    strobe(1'b1, 12'd4000, 1'b0, 1'b0, 1'b0);
    checks++; if (remaining !== 12'd3600) begin errors++; $display("FAIL clamp_remaining: got %0d want 3600", remaining); end
    wait_valid(ok, n);
    checks++; if (!ok || n > 22) begin errors++; $display("FAIL clamp_latency: got ok=%0d cycles=%0d want <=22", ok, n); end
    checks++; if (digs() !== 16'h6000) begin errors++; $display("FAIL clamp_digits: got %h want 6000", digs()); end
  endtask

  task automatic test_countdown();
    bit ok; int n;
    strobe(1'b1, 12'd3, 1'b0, 1'b0, 1'b0);
    wait_valid(ok, n);
    strobe(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL cd_running: got %b want 1", running); end
    strobe(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (remaining !== 12'd2 || alarm_pulse !== 1'b0) begin errors++; $display("FAIL cd_tick1: got rem=%0d alarm=%b want rem=2 alarm=0", remaining, alarm_pulse); end
    repeat (3) cyc();
    strobe(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (remaining !== 12'd1 || alarm_pulse !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL cd_tick2: got rem=%0d alarm=%b exp=%b want 1 0 0", remaining, alarm_pulse, expired); end
    repeat (3) cyc();
    strobe(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (remaining !== 12'd0 || alarm_pulse !== 1'b1 || expired !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL cd_expire: got rem=%0d alarm=%b exp=%b run=%b want 0 1 1 0", remaining, alarm_pulse, expired, running); end
    cyc();
    checks++; if (alarm_pulse !== 1'b0 || expired !== 1'b1) begin errors++; $display("FAIL cd_after: got alarm=%b exp=%b want 0 1", alarm_pulse, expired); end
    strobe(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (remaining !== 12'd0 || expired !== 1'b1) begin errors++; $display("FAIL cd_extra_tick: got rem=%0d exp=%b want 0 1", remaining, expired); end
    strobe(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL cd_ss_expired: got run=%b want 0", running); end
    wait_valid(ok, n);
    checks++; if (!ok || digs() !== 16'h0000) begin errors++; $display("FAIL cd_digits: got ok=%0d %h want 0000", ok, digs()); end
  endtask

  task automatic test_pause_priority();
    strobe(1'b1, 12'd10, 1'b0, 1'b0, 1'b0);
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL pp_load_clears_exp: got %b want 0", expired); end
    strobe(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pp_run: got %b want 1", running); end
    strobe(1'b0, 12'd0, 1'b1, 1'b0, 1'b1);
    checks++; if (running !== 1'b0 || remaining !== 12'd10) begin errors++; $display("FAIL pp_ss_beats_tick: got run=%b rem=%0d want 0 10", running, remaining); end
    strobe(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (remaining !== 12'd10) begin errors++; $display("FAIL pp_tick_paused: got %0d want 10", remaining); end
    strobe(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pp_resume: got %b want 1", running); end
    strobe(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (remaining !== 12'd9) begin errors++; $display("FAIL pp_tick_run: got %0d want 9", remaining); end
    strobe(1'b0, 12'd0, 1'b0, 1'b1, 1'b0);
    checks++; if (remaining !== 12'd0 || running !== 1'b0) begin errors++; $display("FAIL pp_clear: got rem=%0d run=%b want 0 0", remaining, running); end
  endtask

  task automatic test_ignored();
    strobe(1'b1, 12'd20, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    strobe(1'b1, 12'd50, 1'b0, 1'b0, 1'b0);
    checks++; if (remaining !== 12'd20 || running !== 1'b1) begin errors++; $display("FAIL ig_load_running: got rem=%0d run=%b want 20 1", remaining, running); end
    strobe(1'b1, 12'd30, 1'b0, 1'b1, 1'b0);
    checks++; if (remaining !== 12'd0 || running !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL ig_clear_load: got rem=%0d run=%b exp=%b want 0 0 0", remaining, running, expired); end
    strobe(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ig_ss_idle: got %b want 0", running); end
    strobe(1'b1, 12'd0, 1'b0, 1'b0, 1'b0);
    checks++; if (remaining !== 12'd0) begin errors++; $display("FAIL ig_load0: got %0d want 0", remaining); end
    strobe(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ig_ss_after_load0: got %b want 0", running); end
  endtask

  task automatic test_restart();
    bit ok; bit stale; int n;
    bit ok0; int n0;
    wait_valid(ok0, n0);
    strobe(1'b1, 12'd599, 1'b0, 1'b0, 1'b0);
    checks++; if (digits_valid !== 1'b0 || remaining !== 12'd599) begin errors++; $display("FAIL rs_first: got dv=%b rem=%0d want 0 599", digits_valid, remaining); end
    cyc();
    checks++; if (digits_valid !== 1'b0) begin errors++; $display("FAIL rs_mid_dv: got %b want 0", digits_valid); end
    strobe(1'b1, 12'd61, 1'b0, 1'b0, 1'b0);
    stale = 1'b0;
    ok = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (digits_valid) begin
        ok = 1'b1;
        if (digs() === 16'h0959) stale = 1'b1;
        break;
      end
      cyc();
      n++;
    end
    checks++; if (stale) begin errors++; $display("FAIL rs_stale: got digits %h published want never 0959", digs()); end
    checks++; if (!ok || n > 22) begin errors++; $display("FAIL rs_latency: got ok=%0d cycles=%0d want <=22", ok, n); end
    checks++; if (digs() !== 16'h0101 || remaining !== 12'd61) begin errors++; $display("FAIL rs_digits: got %h rem=%0d want 0101 61", digs(), remaining); end
  endtask

  task automatic test_reset_midcount();
    bit ok; int n;
    strobe(1'b1, 12'd126, 1'b0, 1'b0, 1'b0);
    strobe(1'b0, 12'd0, 1'b1, 1'b0, 1'b0);
    strobe(1'b0, 12'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (remaining !== 12'd125 || running !== 1'b1) begin errors++; $display("FAIL rm_pre: got rem=%0d run=%b want 125 1", remaining, running); end
    wait_valid(ok, n);
    checks++; if (digs() !== 16'h0205) begin errors++; $display("FAIL rm_digits125: got %h want 0205", digs()); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (remaining !== 12'd0 || digs() !== 16'h0000) begin errors++; $display("FAIL rm_async: got rem=%0d digits=%h want 0 0000", remaining, digs()); end
    checks++; if (digits_valid !== 1'b1 || running !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL rm_flags: got dv=%b run=%b exp=%b want 1 0 0", digits_valid, running, expired); end
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_convert();
    test_countdown();
    test_pause_priority();
    test_ignored();
    test_restart();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
